// File: rtl/axpy_pkg.sv
// Shared constants and types for the AXPY engine: register map, FSM states and Q16.16 limits.
package axpy_pkg;
  localparam int FRAC_DEF = 16;

  localparam logic [7:0] REG_CTRL   = 8'h00;
  localparam logic [7:0] REG_STATUS = 8'h01;
  localparam logic [7:0] REG_LEN    = 8'h02;
  localparam logic [7:0] REG_A      = 8'h03;
  localparam logic [7:0] REG_B      = 8'h04;
  localparam logic [7:0] REG_CYCLES = 8'h05;

  localparam logic signed [31:0] Q_MAX = 32'sh7FFF_FFFF;
  localparam logic signed [31:0] Q_MIN = 32'sh8000_0000;
  localparam logic signed [31:0] Q_ONE = 32'sh0001_0000;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/axpy_if.sv
// The three Avalon-MM masters exported by the Qsys system, bundled as one bus.
interface axpy_if;
  logic        data_in_write;
  logic [7:0]  data_in_address;
  logic [31:0] data_in_writedata;

  logic        data_control_read;
  logic        data_control_write;
  logic [7:0]  data_control_address;
  logic [31:0] data_control_writedata;
  logic [31:0] data_control_readdata;

  logic        data_out_read;
  logic [7:0]  data_out_address;
  logic [31:0] data_out_readdata;

  modport master (
    output data_in_write, data_in_address, data_in_writedata,
    output data_control_read, data_control_write, data_control_address, data_control_writedata,
    output data_out_read, data_out_address,
    input  data_control_readdata, data_out_readdata
  );

  modport slave (
    input  data_in_write, data_in_address, data_in_writedata,
    input  data_control_read, data_control_write, data_control_address, data_control_writedata,
    input  data_out_read, data_out_address,
    output data_control_readdata, data_out_readdata
  );
endinterface

// File: rtl/dp_ram_256x32.sv
// Simple dual-port RAM: one write port, one registered read port whose output holds between reads.
module dp_ram_256x32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [7:0]  waddr,
  input  logic [31:0] wdata,
  input  logic        re,
  input  logic [7:0]  raddr,
  output logic [31:0] rdata
);
  logic [31:0] mem [256];

  // Array content is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/axpy_engine.sv
// out[i] = A*in[i] + B in signed Q16.16 over LEN words, 3-stage pipeline behind an Avalon-MM register file.
// Define AXPY_SATURATE_EN to saturate results and report clipping in STATUS.ovf; otherwise results wrap.
module axpy_engine
  import axpy_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int FRAC  = FRAC_DEF
) (
  input logic   clk_clk,
  input logic   reset_reset,
  axpy_if.slave bus
);
`ifdef AXPY_SATURATE_EN
  localparam int SW = 64;
`else
  localparam int SW = 32;
`endif
  localparam int STAGES = 2;

  state_t             state_q, state_d;
  logic [8:0]         len_q;
  logic signed [31:0] a_q, b_q;
  logic               done_q, ovf;
  logic [31:0]        cycles_q, run_cnt;
  logic [7:0]         cnt, addr_s1, addr_s2;
  logic [STAGES-1:0]  vld_pipe;
  logic [31:0]        x_raw, res;
  logic signed [63:0] a_ext, x_ext;
  logic signed [SW-1:0] sh_q;

  logic busy, issue, ctrl_wr, cfg_wr, start, run_start, clr_done, drain_done;

  assign busy      = (state_q == RUN) || (state_q == DRAIN);
  assign issue     = (state_q == RUN);
  assign ctrl_wr   = bus.data_control_write && (bus.data_control_address == REG_CTRL);
  assign cfg_wr    = bus.data_control_write && !busy;
  assign start     = ctrl_wr && bus.data_control_writedata[0] && !busy;
  assign clr_done  = ctrl_wr && bus.data_control_writedata[1];
  assign run_start = start && (len_q != 9'd0);
  assign drain_done = (state_q == DRAIN) && (vld_pipe == '0);

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) state_q <= IDLE;
    else             state_q <= state_d;
  end

  // DONE lasts one cycle and accepts START like IDLE, so back-to-back runs are not dropped.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) state_d = run_start ? RUN : DONE;
      end
      RUN:     if ({1'b0, cnt} == len_q - 9'd1) state_d = DRAIN;
      DRAIN:   if (vld_pipe == '0) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      len_q    <= '0;
      a_q      <= Q_ONE;
      b_q      <= '0;
      done_q   <= 1'b0;
      cycles_q <= '0;
      run_cnt  <= '0;
      cnt      <= '0;
      vld_pipe <= '0;
    end else begin
      if (cfg_wr && bus.data_control_address == REG_LEN)
        len_q <= (bus.data_control_writedata > 32'(DEPTH)) ? 9'(DEPTH)
                                                           : bus.data_control_writedata[8:0];
      if (cfg_wr && bus.data_control_address == REG_A) a_q <= bus.data_control_writedata;
      if (cfg_wr && bus.data_control_address == REG_B) b_q <= bus.data_control_writedata;

      if (state_d == DONE)         done_q <= 1'b1;
      else if (start || clr_done)  done_q <= 1'b0;

      // CYCLES counts every busy cycle, including the final DRAIN cycle being left now.
      if (run_start)       cycles_q <= '0;
      else if (drain_done) cycles_q <= run_cnt + 32'd1;

      if (run_start) run_cnt <= '0;
      else if (busy) run_cnt <= run_cnt + 32'd1;

      if (run_start)  cnt <= '0;
      else if (issue) cnt <= cnt + 8'd1;

      vld_pipe <= {vld_pipe[STAGES-2:0], issue};
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      bus.data_control_readdata <= '0;
    end else if (bus.data_control_read) begin
      case (bus.data_control_address)
        REG_STATUS: bus.data_control_readdata <= {29'd0, ovf, done_q, busy};
        REG_LEN:    bus.data_control_readdata <= {23'd0, len_q};
        REG_A:      bus.data_control_readdata <= a_q;
        REG_B:      bus.data_control_readdata <= b_q;
        REG_CYCLES: bus.data_control_readdata <= cycles_q;
        default:    bus.data_control_readdata <= '0;
      endcase
    end
  end

  dp_ram_256x32 u_in_ram (
    .clk   (clk_clk),
    .rst   (reset_reset),
    .we    (bus.data_in_write && !busy),
    .waddr (bus.data_in_address),
    .wdata (bus.data_in_writedata),
    .re    (issue),
    .raddr (cnt),
    .rdata (x_raw)
  );

  // S2: full-width signed product, arithmetic shift back to Q16.16.
  assign a_ext = 64'(a_q);
  assign x_ext = 64'($signed(x_raw));

  always_ff @(posedge clk_clk) begin
    addr_s1 <= cnt;
    addr_s2 <= addr_s1;
    sh_q    <= SW'((a_ext * x_ext) >>> FRAC);
  end

`ifdef AXPY_SATURATE_EN
  logic signed [63:0] sum;
  logic               clip;

  assign sum = sh_q + 64'(b_q);

  always_comb begin
    res  = sum[31:0];
    clip = 1'b0;
    if (sum > 64'(Q_MAX)) begin
      res  = Q_MAX;
      clip = 1'b1;
    end else if (sum < 64'(Q_MIN)) begin
      res  = Q_MIN;
      clip = 1'b1;
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset)                  ovf <= 1'b0;
    else if (run_start)               ovf <= 1'b0;
    else if (vld_pipe[1] && clip)     ovf <= 1'b1;
  end
`else
  assign res = sh_q + b_q;
  assign ovf = 1'b0;
`endif

  dp_ram_256x32 u_out_ram (
    .clk   (clk_clk),
    .rst   (reset_reset),
    .we    (vld_pipe[1]),
    .waddr (addr_s2),
    .wdata (res),
    .re    (bus.data_out_read),
    .raddr (bus.data_out_address),
    .rdata (bus.data_out_readdata)
  );
endmodule

// File: tb/tb_axpy_engine.sv
// Directed bench for axpy_engine: stimulus pushes expected read data, a monitor pops and compares.
module tb_axpy_engine;
  import axpy_pkg::*;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

`ifdef AXPY_SATURATE_EN
  localparam logic [31:0] SAT_OUT = 32'h7FFF_FFFF;
  localparam logic [31:0] SAT_ST  = 32'd6;
`else
  localparam logic [31:0] SAT_OUT = 32'h0001_0000;
  localparam logic [31:0] SAT_ST  = 32'd2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  axpy_if bus ();

  axpy_engine dut (
    .clk_clk     (clk),
    .reset_reset (rst),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t ctl_q[$];
  exp_t out_q[$];
  logic ctl_pend = 1'b0;
  logic out_pend = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  // Readdata for a strobe seen at a rising edge is compared on the following falling edge.
  always @(posedge clk) begin
    ctl_pend <= bus.data_control_read;
    out_pend <= bus.data_out_read;
  end

  always @(negedge clk) begin
    exp_t e;
    if (ctl_pend) begin
      if (ctl_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL ctl_unexpected got %h want none", bus.data_control_readdata);
      end else begin
        e = ctl_q.pop_front();
        check(e.name, bus.data_control_readdata, e.val);
      end
    end
    if (out_pend) begin
      if (out_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL out_unexpected got %h want none", bus.data_out_readdata);
      end else begin
        e = out_q.pop_front();
        check(e.name, bus.data_out_readdata, e.val);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic reg_wr(input logic [7:0] a, input logic [31:0] d);
    bus.data_control_write     = 1'b1;
    bus.data_control_address   = a;
    bus.data_control_writedata = d;
    tick();
    bus.data_control_write = 1'b0;
  endtask

  task automatic reg_rd(input logic [7:0] a, input logic [31:0] want, input string name);
    bus.data_control_read    = 1'b1;
    bus.data_control_address = a;
    ctl_q.push_back(exp_t'{name, want});
    tick();
    bus.data_control_read = 1'b0;
  endtask

  task automatic in_wr(input logic [7:0] a, input logic [31:0] d);
    bus.data_in_write     = 1'b1;
    bus.data_in_address   = a;
    bus.data_in_writedata = d;
    tick();
    bus.data_in_write = 1'b0;
  endtask

  task automatic out_rd(input logic [7:0] a, input logic [31:0] want, input string name);
    bus.data_out_read    = 1'b1;
    bus.data_out_address = a;
    out_q.push_back(exp_t'{name, want});
    tick();
    bus.data_out_read = 1'b0;
  endtask

  initial begin
    bus.data_in_write = 1'b0;          bus.data_in_address = '0;      bus.data_in_writedata = '0;
    bus.data_control_read = 1'b0;      bus.data_control_write = 1'b0;
    bus.data_control_address = '0;     bus.data_control_writedata = '0;
    bus.data_out_read = 1'b0;          bus.data_out_address = '0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    tick();

    // register defaults
    for (int i = 0; i < 7; i++) reg_rd(8'(i), (i == 3) ? 32'h0001_0000 : 32'h0, "reset_default");

    // basic run: 2.0*3.0 + 1.0 = 7.0, busy T+1..T+4, done at T+5
    in_wr(8'd0, 32'h0003_0000);
    reg_wr(REG_A, 32'h0002_0000);
    reg_wr(REG_B, 32'h0001_0000);
    reg_wr(REG_LEN, 32'd1);
    reg_wr(REG_CTRL, 32'd1);
    for (int k = 1; k <= 5; k++) reg_rd(REG_STATUS, (k < 5) ? 32'd1 : 32'd2, "basic_status");
    reg_rd(REG_CYCLES, 32'd4, "basic_cycles");
    out_rd(8'd0, 32'h0007_0000, "basic_out");
    reg_wr(REG_CTRL, 32'd2);
    reg_rd(REG_STATUS, 32'd0, "clr_done");

    // full buffer with A=-1.0
    for (int i = 0; i < 256; i++) in_wr(8'(i), 32'(i) << 16);
    reg_wr(REG_LEN, 32'd300);
    reg_rd(REG_LEN, 32'd256, "len_clamp");
    reg_wr(REG_A, 32'hFFFF_0000);
    reg_wr(REG_B, 32'h0);
    reg_wr(REG_CTRL, 32'd1);
    for (int k = 1; k <= 260; k++) reg_rd(REG_STATUS, (k < 260) ? 32'd1 : 32'd2, "full_busy");
    reg_rd(REG_CYCLES, 32'd259, "full_cycles");
    out_rd(8'd255, 32'hFF01_0000, "full_out255");
    out_rd(8'd0,   32'h0000_0000, "full_out0");
    out_rd(8'd1,   32'hFFFF_0000, "full_out1");
    out_rd(8'd128, 32'hFF80_0000, "full_out128");

    // writes during busy must be ignored
    reg_wr(REG_CTRL, 32'd1);
    reg_wr(REG_LEN, 32'd5);
    reg_wr(REG_A, 32'h0002_0000);
    reg_wr(REG_CTRL, 32'd1);
    in_wr(8'd255, 32'h0001_2345);
    idle(265);
    reg_rd(REG_LEN, 32'd256, "busy_len");
    reg_rd(REG_A, 32'hFFFF_0000, "busy_a");
    reg_rd(REG_CYCLES, 32'd259, "busy_cycles");
    out_rd(8'd255, 32'hFF01_0000, "busy_out255");

    // START with LEN=0 goes straight to done
    reg_wr(REG_CTRL, 32'd2);
    reg_rd(REG_STATUS, 32'd0, "clr_done2");
    reg_wr(REG_LEN, 32'd0);
    reg_wr(REG_CTRL, 32'd1);
    for (int k = 1; k <= 3; k++) reg_rd(REG_STATUS, 32'd2, "len0_status");
    reg_rd(REG_CYCLES, 32'd259, "len0_cycles");

    // same-cycle read and write returns the old value
    bus.data_control_write     = 1'b1;
    bus.data_control_read      = 1'b1;
    bus.data_control_address   = REG_B;
    bus.data_control_writedata = 32'd5;
    ctl_q.push_back(exp_t'{"rw_pre", 32'h0});
    tick();
    bus.data_control_write = 1'b0;
    bus.data_control_read  = 1'b0;
    reg_rd(REG_B, 32'd5, "rw_post");

    // overflow: saturate or wrap depending on build
    in_wr(8'd0, 32'h7FFF_0000);
    reg_wr(REG_A, 32'h7FFF_0000);
    reg_wr(REG_B, 32'h0);
    reg_wr(REG_LEN, 32'd1);
    reg_wr(REG_CTRL, 32'd1);
    idle(6);
    out_rd(8'd0, SAT_OUT, "sat_out");
    reg_rd(REG_STATUS, SAT_ST, "sat_status");

    // reset in the middle of a run
    reg_wr(REG_A, 32'h0001_0000);
    reg_wr(REG_LEN, 32'd100);
    out_rd(8'd255, 32'hFF01_0000, "pre_rst_out");
    reg_wr(REG_CTRL, 32'd1);
    reg_rd(REG_STATUS, 32'd1, "ovf_clear");
    reg_rd(REG_LEN, 32'd100, "pre_rst_len");
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_ctl_rdata", bus.data_control_readdata, 32'h0);
    check("rst_out_rdata", bus.data_out_readdata, 32'h0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    tick();
    reg_rd(REG_STATUS, 32'd0, "post_rst_status");
    reg_rd(REG_LEN, 32'd0, "post_rst_len");
    reg_rd(REG_A, 32'h0001_0000, "post_rst_a");

    // fresh run after reset
    reg_wr(REG_LEN, 32'd3);
    reg_wr(REG_CTRL, 32'd1);
    idle(8);
    reg_rd(REG_STATUS, 32'd2, "post_status");
    reg_rd(REG_CYCLES, 32'd6, "post_cycles");
    out_rd(8'd0, 32'h7FFF_0000, "post_out0");
    out_rd(8'd1, 32'h0001_0000, "post_out1");
    out_rd(8'd2, 32'h0002_0000, "post_out2");

    idle(3);
    check("ctl_q_drain", 32'(ctl_q.size()), 32'd0);
    check("out_q_drain", 32'(out_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
